osc_capture: RTL
================

# osc_capture

Trigger-and-capture stage directly downstream of the 4-channel ADC front end. Takes one corrected 12-bit channel stream (sample plus one-cycle valid strobe), keeps a circular record in on-chip RAM, detects a rising or falling level crossing, and freezes a record with a programmable number of pre-trigger samples. The CPU then reads the frozen record by trigger-relative offset.

## Interface
- `AW`, 9: RAM address width; record depth `DEPTH = 2**AW` samples.
- `DW`, 12: sample width.
- `AUTO_SAMPLES`, 65535: auto-trigger timeout in valid samples. Used only with `OSC_AUTO_TRIG_EN`.

- `clk`  in  1  48 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  DW  unsigned sample from the ADC stage.
- `din_v`  in  1  one-cycle strobe; `din` is valid this cycle.
- `arm`  in  1  one-cycle pulse; starts a new capture.
- `trig_level`  in  DW  unsigned trigger threshold.
- `trig_slope`  in  1  0 = rising, 1 = falling.
- `pretrig`  in  AW  samples kept before the trigger sample; sampled on `arm`.
- `rd_addr`  in  AW  record offset; 0 = oldest sample.
- `rd_data`  out  DW  registered RAM read data.
- `busy`  out  1  capture in progress.
- `done`  out  1  record frozen and readable.
- `trig_addr`  out  AW  physical RAM address of the trigger sample.
- `auto_trig`  out  1  last record was auto-triggered (always 0 without the macro).

## Operation
- States: IDLE, PRE, WAIT, POST, DONE. `reset` forces IDLE.
- Reset values: `busy`=0, `done`=0, `trig_addr`=0, `rd_data`=0, `auto_trig`=0. Write pointer, counters and `prev_v` are all 0.
- `arm` in any state latches `pretrig`, clears counters, `prev_v`, `done` and `auto_trig`, then enters:
  - PRE if `pretrig`≠0;
  - WAIT if `pretrig`=0.
- The write pointer is not reset by `arm`.
- Every `din_v` in PRE, WAIT or POST writes `din` at `wptr`, then `wptr` = `wptr`+1 mod DEPTH.
- In every state, each `din_v` stores `prev` = `din` and sets `prev_v` = 1.
- PRE: after `pretrig` written samples, go to WAIT.
- WAIT: evaluate on each `din_v` with `prev_v`=1.
  - Rising: `prev` < `trig_level` and `din` ≥ `trig_level`.
  - Falling: `prev` ≥ `trig_level` and `din` < `trig_level`.
  - On a hit, write the sample and latch `trig_addr` = `wptr`.
  - Then go to POST, or to DONE if `DEPTH-1-pretrig` = 0.
- POST: write `DEPTH-1-pretrig` further samples, then go to DONE.
- DONE: no RAM writes; `done`=1. Exit only via `arm` or reset.
- Record start = (`trig_addr` − `pretrig`) mod DEPTH. Read address = (start + `rd_addr`) mod DEPTH, in AW-bit wrap arithmetic.
- Reads are allowed in any state. Data is meaningful only while `done`=1.
- Comparisons are unsigned, full DW width.

## Timing
- `busy` rises the cycle after `arm` and falls in the same edge that `done` rises.
- `done` rises one cycle after the clock edge that writes the final POST sample (or the trigger sample when POST is empty).
- `rd_data` has 1-cycle latency from `rd_addr`.
- Simultaneous `arm` and `din_v`: `arm` wins; that sample is not written.
- `din_v` gaps of any length are allowed; only valid samples count.
- Async reset in mid-capture: all outputs return to reset values immediately. RAM contents are not cleared.

## Configuration
- `OSC_AUTO_TRIG_EN` defined:
  - WAIT counts valid samples.
  - On the `AUTO_SAMPLES`-th sample without a hit, that sample is treated as the trigger and `auto_trig` is set to 1.
  - The counter clears on entry to WAIT.
- Not defined: no counter; WAIT holds until a real crossing; `auto_trig` is tied to 0.

## Test plan
- Rising trigger, AW=4, `pretrig`=4, `din`=10·n (n=0,1,…), `trig_level`=55 -> `trig_addr`=6; `done` after n=17; `rd_addr` 0..15 returns 20,30,…,170 (`rd_addr`=4 → 60).
- Falling trigger, `pretrig`=0, `din`=4095 ×5 then 0, `trig_level`=2048 -> trigger on the first 0. The first WAIT sample never triggers.
- Auto trigger with macro, `AUTO_SAMPLES`=32, constant `din`=100, `trig_level`=2000 -> trigger on the 32nd WAIT sample, `auto_trig`=1. Without macro -> `busy` stays 1 indefinitely.
- `pretrig`=DEPTH−1 -> DONE on the trigger-sample edge+1; `rd_addr`=DEPTH−1 returns the trigger sample.
- Re-`arm` during WAIT, then reset (low) during POST -> the capture restarts in PRE with counts cleared; reset drops `busy`/`done` to 0 asynchronously.
- Sparse `din_v` (1 in 6 cycles, as from the ADC stage) -> the same record contents as the dense test.

Source files
------------

// File: rtl/osc_capture.sv
// Trigger-and-capture stage: circular sample record, level-crossing trigger, pre-trigger window.
// Optional auto-trigger timeout enabled by defining OSC_AUTO_TRIG_EN.
//
// state | meaning
// IDLE  | after reset, nothing captured
// PRE   | filling the pre-trigger window
// WAIT  | recording, looking for a crossing
// POST  | recording samples after the trigger
// DONE  | record frozen and readable
module osc_capture #(
  parameter int AW           = 9,
  parameter int DW           = 12,
  parameter int AUTO_SAMPLES = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          din_v,
  input  logic          arm,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic [AW-1:0] pretrig,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic          auto_trig
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, wptr_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] pre_r, pre_nxt;
  logic [AW-1:0] trig_nxt;
  logic [DW-1:0] prev, prev_nxt;
  logic          prev_v, prev_v_nxt;
  logic          busy_nxt, done_nxt;
  logic          we;
  logic          real_hit, hit;
  logic [AW-1:0] rd_phys;
  logic [DW-1:0] mem [DEPTH];

`ifdef OSC_AUTO_TRIG_EN
  localparam int ACW = $clog2(AUTO_SAMPLES + 1);
  logic [ACW-1:0] acnt, acnt_nxt;
  logic           auto_hit, auto_r, auto_nxt;
  assign auto_hit  = (acnt == ACW'(AUTO_SAMPLES - 1));
  assign auto_trig = auto_r;
`else
  assign auto_trig = 1'b0;
`endif

  assign real_hit = prev_v && (trig_slope ? ((prev >= trig_level) && (din <  trig_level))
                                          : ((prev <  trig_level) && (din >= trig_level)));
`ifdef OSC_AUTO_TRIG_EN
  assign hit = real_hit || auto_hit;
`else
  assign hit = real_hit;
`endif

  // cnt is a down-counter of samples still owed to the PRE or POST phase
  always_comb begin
    state_nxt  = state;
    wptr_nxt   = wptr;
    cnt_nxt    = cnt;
    pre_nxt    = pre_r;
    trig_nxt   = trig_addr;
    prev_nxt   = prev;
    prev_v_nxt = prev_v;
    busy_nxt   = busy;
    done_nxt   = done;
    we         = 1'b0;
`ifdef OSC_AUTO_TRIG_EN
    acnt_nxt   = acnt;
    auto_nxt   = auto_r;
`endif
    if (arm) begin
      pre_nxt    = pretrig;
      cnt_nxt    = pretrig;
      prev_v_nxt = 1'b0;
      done_nxt   = 1'b0;
      busy_nxt   = 1'b1;
      state_nxt  = (pretrig != '0) ? PRE : WAIT;
`ifdef OSC_AUTO_TRIG_EN
      acnt_nxt   = '0;
      auto_nxt   = 1'b0;
`endif
    end else begin
      if (din_v) begin
        prev_nxt   = din;
        prev_v_nxt = 1'b1;
      end
      case (state)
        PRE: if (din_v) begin
          we      = 1'b1;
          cnt_nxt = cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state_nxt = WAIT;
`ifdef OSC_AUTO_TRIG_EN
            acnt_nxt  = '0;
`endif
          end
        end
        WAIT: if (din_v) begin
          we = 1'b1;
          if (hit) begin
            trig_nxt  = wptr;
            cnt_nxt   = ~pre_r;
            state_nxt = (~pre_r == '0) ? DONE : POST;
`ifdef OSC_AUTO_TRIG_EN
            auto_nxt  = !real_hit;
`endif
          end
`ifdef OSC_AUTO_TRIG_EN
          else acnt_nxt = acnt + ACW'(1);
`endif
        end
        POST: if (din_v) begin
          we      = 1'b1;
          cnt_nxt = cnt - AW'(1);
          if (cnt == AW'(1)) state_nxt = DONE;
        end
        DONE: begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
        default: ;
      endcase
    end
    if (we) wptr_nxt = wptr + AW'(1);
  end

  assign rd_phys = trig_addr - pre_r + rd_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wptr      <= '0;
      cnt       <= '0;
      pre_r     <= '0;
      trig_addr <= '0;
      prev      <= '0;
      prev_v    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
`ifdef OSC_AUTO_TRIG_EN
      acnt      <= '0;
      auto_r    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      wptr      <= wptr_nxt;
      cnt       <= cnt_nxt;
      pre_r     <= pre_nxt;
      trig_addr <= trig_nxt;
      prev      <= prev_nxt;
      prev_v    <= prev_v_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      rd_data   <= mem[rd_phys];
`ifdef OSC_AUTO_TRIG_EN
      acnt      <= acnt_nxt;
      auto_r    <= auto_nxt;
`endif
    end
  end

  // Record RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= din;
  end

endmodule
